// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter_if
// Brief    : Read-path bundle for the N-master to 1-slave AXI4 read arbiter.
//            Carries the flat master-side AR/R buses and the slave-side AR/R
//            channel. "slave" modport is the arbiter's view, "master" is the
//            view of the surrounding masters plus memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_rd_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 8
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Master side (flat, master i at [i*W +: W])
  logic [NUM_MASTERS*ID_W-1:0]   m_arid;
  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr;
  logic [NUM_MASTERS*8-1:0]      m_arlen;
  logic [NUM_MASTERS*3-1:0]      m_arsize;
  logic [NUM_MASTERS*2-1:0]      m_arburst;
  logic [NUM_MASTERS-1:0]        m_arvalid;
  logic [NUM_MASTERS-1:0]        m_arready;
  logic [NUM_MASTERS*ID_W-1:0]   m_rid;
  logic [NUM_MASTERS*DATA_W-1:0] m_rdata;
  logic [NUM_MASTERS*2-1:0]      m_rresp;
  logic [NUM_MASTERS-1:0]        m_rlast;
  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [NUM_MASTERS-1:0]        m_rready;

  // Slave side
  logic [ID_W+IDX_W-1:0]         s_arid;
  logic [ADDR_W-1:0]             s_araddr;
  logic [7:0]                    s_arlen;
  logic [2:0]                    s_arsize;
  logic [1:0]                    s_arburst;
  logic                          s_arvalid;
  logic                          s_arready;
  logic [ID_W+IDX_W-1:0]         s_rid;
  logic [DATA_W-1:0]             s_rdata;
  logic [1:0]                    s_rresp;
  logic                          s_rlast;
  logic                          s_rvalid;
  logic                          s_rready;

  // Arbiter view
  modport slave (
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
  );

  // Environment view (masters + shared memory read port)
  modport master (
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
    output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : Round-robin N-master to 1-slave AXI4 read arbiter. One burst in
//            flight; slave ARID is {grant index, master ARID}; R beats are
//            routed to the granted master until RLAST.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 8
) (
  input  logic              aclk,
  input  logic              areset,
  axi_rd_arbiter_if.slave   bus
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_rr_grant;
  logic [31:0]      w_gidx;
  logic             w_any_req;
  logic             w_ar_hs;
  logic             w_r_done;
  logic             w_unused_rid;

  assign w_gidx    = 32'(r_grant);
  assign w_any_req = |bus.m_arvalid;
  assign w_ar_hs   = (r_state == S_ADDR) & bus.m_arvalid[r_grant] & bus.s_arready;
  assign w_r_done  = (r_state == S_DATA) & bus.s_rvalid & bus.m_rready[r_grant]
                     & bus.s_rlast;

  // Only the low ID bits travel back; the index bits are implied by the grant
  assign w_unused_rid = &{1'b0, bus.s_rid[ID_W+IDX_W-1:ID_W]};

  // R payload is broadcast; only m_rvalid qualifies it per master
  assign bus.m_rid   = {NUM_MASTERS{bus.s_rid[ID_W-1:0]}};
  assign bus.m_rdata = {NUM_MASTERS{bus.s_rdata}};
  assign bus.m_rresp = {NUM_MASTERS{bus.s_rresp}};
  assign bus.m_rlast = {NUM_MASTERS{bus.s_rlast}};

  // Round-robin pick: first requester scanning upward from last_grant+1.
  // Loop runs far-to-near so the nearest requester is assigned last and wins.
  always_comb begin
    w_rr_grant = r_last_grant;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (bus.m_arvalid[(32'(r_last_grant) + 32'(k)) % 32'(NUM_MASTERS)]) begin
        w_rr_grant = IDX_W'((32'(r_last_grant) + 32'(k)) % 32'(NUM_MASTERS));
      end
    end
  end

  // State, grant and last-grant registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && w_any_req) begin
        r_grant <= w_rr_grant;
      end
      if (w_r_done) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Next-state: one burst at a time, grant held until AR handshake
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_ADDR;
      S_ADDR:  if (w_ar_hs)   w_next_state = S_DATA;
      S_DATA:  if (w_r_done)  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs: combinational pass-through of the granted master in ADDR/DATA
  always_comb begin
    bus.m_arready = '0;
    bus.m_rvalid  = '0;
    bus.s_arid    = '0;
    bus.s_araddr  = '0;
    bus.s_arlen   = '0;
    bus.s_arsize  = '0;
    bus.s_arburst = '0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    case (r_state)
      S_ADDR: begin
        bus.s_arvalid          = bus.m_arvalid[r_grant];
        bus.s_arid             = {r_grant, bus.m_arid[w_gidx*ID_W +: ID_W]};
        bus.s_araddr           = bus.m_araddr[w_gidx*ADDR_W +: ADDR_W];
        bus.s_arlen            = bus.m_arlen[w_gidx*8 +: 8];
        bus.s_arsize           = bus.m_arsize[w_gidx*3 +: 3];
        bus.s_arburst          = bus.m_arburst[w_gidx*2 +: 2];
        bus.m_arready[r_grant] = bus.s_arready;
      end
      S_DATA: begin
        bus.m_rvalid[r_grant] = bus.s_rvalid;
        bus.s_rready          = bus.m_rready[r_grant];
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire
